ldpc_vnode_update: RTL and testbench

- Variable-node stage of the layered LDPC decoder; it wraps the check-node min-sign stage on both sides.
- Upstream: it takes 6 posterior LLRs plus the 6 old check messages for one row and computes extrinsic Q = sat(L − R_old). Q is sent to the min-sign stage.
- Downstream: it holds Q in a matched delay line. When the new check messages R_new return, it emits updated posteriors L_new = sat(Q + R_new).
- It also tracks in-flight rows and flags return-timing errors.

---
 rtl/ldpc_vnode_update_if.sv | 27 ++
 rtl/ldpc_vnode_update.sv | 86 ++++++++
 tb/tb_ldpc_vnode_update.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_vnode_update_if.sv
// rtl/ldpc_vnode_update_if.sv - row, Q, R and posterior signal bundle for the LDPC variable-node stage
interface ldpc_vnode_update_if #(
  parameter int LANES = 6,
  parameter int WIDTH = 8
);
  logic                   i_valid;
  logic [LANES*WIDTH-1:0] i_l_data;
  logic [LANES*WIDTH-1:0] i_r_old;
  logic                   o_q_valid;
  logic [LANES*WIDTH-1:0] o_q_data;
  logic                   i_r_valid;
  logic [LANES*WIDTH-1:0] i_r_new;
  logic                   o_l_valid;
  logic [LANES*WIDTH-1:0] o_l_data;
  logic                   o_busy;
  logic                   o_align_error;

  modport master (
    output i_valid, i_l_data, i_r_old, i_r_valid, i_r_new,
    input  o_q_valid, o_q_data, o_l_valid, o_l_data, o_busy, o_align_error
  );

  modport slave (
    input  i_valid, i_l_data, i_r_old, i_r_valid, i_r_new,
    output o_q_valid, o_q_data, o_l_valid, o_l_data, o_busy, o_align_error
  );
endinterface

// File: rtl/ldpc_vnode_update.sv
// rtl/ldpc_vnode_update.sv - LDPC variable-node update: Q = sat(L - R_old), L_new = sat(Q + R_new)
module ldpc_vnode_update #(
  parameter int LANES      = 6,
  parameter int WIDTH      = 8,
  parameter int CN_LATENCY = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  ldpc_vnode_update_if.slave bus
);
  localparam int DW = LANES * WIDTH;
  localparam int CW = $clog2(CN_LATENCY + 3);
  localparam logic signed [WIDTH:0] LLR_MAX = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0] LLR_MIN = -LLR_MAX;

  // Symmetric clamp so the min-sign stage can always negate safely.
  function automatic logic [WIDTH-1:0] sat(input logic signed [WIDTH:0] x);
    if (x > LLR_MAX)      return LLR_MAX[WIDTH-1:0];
    else if (x < LLR_MIN) return LLR_MIN[WIDTH-1:0];
    else                  return x[WIDTH-1:0];
  endfunction

  logic          q_valid_r;
  logic [DW-1:0] q_data_r;
  logic [DW-1:0] dl_data [CN_LATENCY];
  logic [CN_LATENCY-1:0] dl_valid;
  logic          l_valid_r;
  logic [DW-1:0] l_data_r;
  logic [CW-1:0] count;
  logic          busy_r;
  logic          align_r;
  logic [DW-1:0] q_next;
  logic [DW-1:0] l_next;
  logic          tail_valid;
  logic [DW-1:0] tail_data;

  assign tail_valid = dl_valid[CN_LATENCY-1];
  assign tail_data  = dl_data[CN_LATENCY-1];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [WIDTH:0] l_x, ro_x, qd_x, rn_x;
    assign l_x  = {bus.i_l_data[k*WIDTH+WIDTH-1], bus.i_l_data[k*WIDTH +: WIDTH]};
    assign ro_x = {bus.i_r_old[k*WIDTH+WIDTH-1],  bus.i_r_old[k*WIDTH +: WIDTH]};
    assign qd_x = {tail_data[k*WIDTH+WIDTH-1],    tail_data[k*WIDTH +: WIDTH]};
    assign rn_x = {bus.i_r_new[k*WIDTH+WIDTH-1],  bus.i_r_new[k*WIDTH +: WIDTH]};
    assign q_next[k*WIDTH +: WIDTH] = sat(l_x - ro_x);
    assign l_next[k*WIDTH +: WIDTH] = sat(qd_x + rn_x);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      q_valid_r <= 1'b0;
      q_data_r  <= '0;
      dl_valid  <= '0;
      for (int i = 0; i < CN_LATENCY; i++) dl_data[i] <= '0;
      l_valid_r <= 1'b0;
      l_data_r  <= '0;
      count     <= '0;
      busy_r    <= 1'b0;
      align_r   <= 1'b0;
    end else begin
      q_valid_r <= bus.i_valid;
      if (bus.i_valid) q_data_r <= q_next;

      // The line is fed from the Q register so its tail lines up with the returning R.
      dl_valid   <= {dl_valid[CN_LATENCY-2:0], q_valid_r};
      dl_data[0] <= q_data_r;
      for (int i = 1; i < CN_LATENCY; i++) dl_data[i] <= dl_data[i-1];

      l_valid_r <= bus.i_r_valid & tail_valid;
      if (bus.i_r_valid & tail_valid) l_data_r <= l_next;
      if (bus.i_r_valid != tail_valid) align_r <= 1'b1;

      if (bus.i_valid & ~tail_valid)      count <= count + CW'(1);
      else if (~bus.i_valid & tail_valid) count <= count - CW'(1);
      busy_r <= (count != '0);
    end
  end

  assign bus.o_q_valid     = q_valid_r;
  assign bus.o_q_data      = q_data_r;
  assign bus.o_l_valid     = l_valid_r;
  assign bus.o_l_data      = l_data_r;
  assign bus.o_busy        = busy_r;
  assign bus.o_align_error = align_r;
endmodule

// File: tb/tb_ldpc_vnode_update.sv
// tb/tb_ldpc_vnode_update.sv - self-checking bench for ldpc_vnode_update
module tb_ldpc_vnode_update;
  localparam int LANES = 6;
  localparam int WIDTH = 8;
  localparam int CN_LATENCY = 5;
  localparam int DW = LANES * WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  ldpc_vnode_update_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

  ldpc_vnode_update #(.LANES(LANES), .WIDTH(WIDTH), .CN_LATENCY(CN_LATENCY)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic int lane(input logic [DW-1:0] v, input int k);
    logic signed [WIDTH-1:0] b;
    b = v[k*WIDTH +: WIDTH];
    return int'(b);
  endfunction

  function automatic int clamp(input int x);
    if (x > 127) return 127;
    if (x < -127) return -127;
    return x;
  endfunction

  function automatic logic [DW-1:0] pack6(input int a0, a1, a2, a3, a4, a5);
    int a[6];
    logic [DW-1:0] r;
    a = '{a0, a1, a2, a3, a4, a5};
    for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = 8'(a[k]);
    return r;
  endfunction

  function automatic logic [DW-1:0] q_ref(input logic [DW-1:0] l, input logic [DW-1:0] ro);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = 8'(clamp(lane(l, k) - lane(ro, k)));
    return r;
  endfunction

  function automatic logic [DW-1:0] l_ref(input logic [DW-1:0] q, input logic [DW-1:0] rn);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = 8'(clamp(lane(q, k) + lane(rn, k)));
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_row();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_valid = 1'b0;
    bus.i_l_data = '0;
    bus.i_r_old = '0;
    bus.i_r_valid = 1'b0;
    bus.i_r_new = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    checks++; if (bus.o_q_valid !== 1'b0) begin failures++; $display("FAIL reset_q_valid got=%b exp=0", bus.o_q_valid); end
    checks++; if (bus.o_q_data !== '0) begin failures++; $display("FAIL reset_q_data got=%h exp=0", bus.o_q_data); end
    checks++; if (bus.o_l_valid !== 1'b0) begin failures++; $display("FAIL reset_l_valid got=%b exp=0", bus.o_l_valid); end
    checks++; if (bus.o_l_data !== '0) begin failures++; $display("FAIL reset_l_data got=%h exp=0", bus.o_l_data); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
    checks++; if (bus.o_align_error !== 1'b0) begin failures++; $display("FAIL reset_align got=%b exp=0", bus.o_align_error); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_row();
    logic [DW-1:0] l, ro, rn, qe;
    l  = pack6(10, -20, 5, 0, 127, -127);
    ro = pack6(3, -5, 10, 0, -10, 10);
    rn = pack6(1, 1, -1, 2, 5, -5);
    qe = q_ref(l, ro);
    bus.i_valid = 1'b1; bus.i_l_data = l; bus.i_r_old = ro;
    step();
    idle_inputs();
    checks++; if (bus.o_q_valid !== 1'b1) begin failures++; $display("FAIL single_q_valid got=%b exp=1", bus.o_q_valid); end
    checks++; if (bus.o_q_data !== pack6(7, -15, -5, 0, 127, -127)) begin failures++; $display("FAIL single_q_data got=%h exp=%h", bus.o_q_data, pack6(7, -15, -5, 0, 127, -127)); end
    checks++; if (bus.o_q_data !== qe) begin failures++; $display("FAIL single_q_model got=%h exp=%h", bus.o_q_data, qe); end
    for (int c = 2; c <= 7; c++) begin
      step();
      if (c < 7) begin
        checks++; if (bus.o_l_valid !== 1'b0) begin failures++; $display("FAIL single_early_l_valid cycle=%0d got=%b exp=0", c, bus.o_l_valid); end
      end else begin
        checks++; if (bus.o_l_valid !== 1'b1) begin failures++; $display("FAIL single_l_valid_lat7 got=%b exp=1", bus.o_l_valid); end
        checks++; if (bus.o_l_data !== pack6(8, -14, -6, 2, 127, -127)) begin failures++; $display("FAIL single_l_data got=%h exp=%h", bus.o_l_data, pack6(8, -14, -6, 2, 127, -127)); end
        checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL single_busy_at_l got=%b exp=1", bus.o_busy); end
      end
      bus.i_r_valid = (c == 6);
      bus.i_r_new = (c == 6) ? rn : '0;
    end
    step();
    checks++; if (bus.o_l_valid !== 1'b0) begin failures++; $display("FAIL single_l_valid_pulse got=%b exp=0", bus.o_l_valid); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", bus.o_busy); end
    checks++; if (bus.o_align_error !== 1'b0) begin failures++; $display("FAIL single_align got=%b exp=0", bus.o_align_error); end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] l, ro, rn;
    l  = pack6(-128, 100, -100, 127, -128, 0);
    ro = pack6(1, 0, 0, -128, 127, 0);
    rn = pack6(0, 100, -100, 1, -1, -128);
    bus.i_valid = 1'b1; bus.i_l_data = l; bus.i_r_old = ro;
    step();
    idle_inputs();
    checks++; if (bus.o_q_data !== pack6(-127, 100, -100, 127, -127, 0)) begin failures++; $display("FAIL sat_q_data got=%h exp=%h", bus.o_q_data, pack6(-127, 100, -100, 127, -127, 0)); end
    for (int c = 2; c <= 7; c++) begin
      step();
      bus.i_r_valid = (c == 6);
      bus.i_r_new = (c == 6) ? rn : '0;
    end
    checks++; if (bus.o_l_valid !== 1'b1) begin failures++; $display("FAIL sat_l_valid got=%b exp=1", bus.o_l_valid); end
    checks++; if (bus.o_l_data !== pack6(-127, 127, -127, 127, -127, -127)) begin failures++; $display("FAIL sat_l_data got=%h exp=%h", bus.o_l_data, pack6(-127, 127, -127, 127, -127, -127)); end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] lr[8], ro[8], qe[8];
    logic exp_qv, exp_lv, exp_busy;
    for (int j = 0; j < 8; j++) begin
      lr[j] = rand_row(); ro[j] = rand_row(); qe[j] = q_ref(lr[j], ro[j]);
    end
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) begin
        step();
        exp_qv = (c <= 8);
        exp_lv = (c >= 7 && c <= 14);
        exp_busy = (c >= 2 && c <= 14);
        checks++; if (bus.o_q_valid !== exp_qv) begin failures++; $display("FAIL b2b_q_valid cycle=%0d got=%b exp=%b", c, bus.o_q_valid, exp_qv); end
        if (exp_qv) begin
          checks++; if (bus.o_q_data !== qe[c-1]) begin failures++; $display("FAIL b2b_q_data cycle=%0d got=%h exp=%h", c, bus.o_q_data, qe[c-1]); end
        end
        checks++; if (bus.o_l_valid !== exp_lv) begin failures++; $display("FAIL b2b_l_valid cycle=%0d got=%b exp=%b", c, bus.o_l_valid, exp_lv); end
        if (exp_lv) begin
          checks++; if (bus.o_l_data !== l_ref(qe[c-7], qe[c-7])) begin failures++; $display("FAIL b2b_l_data cycle=%0d got=%h exp=%h", c, bus.o_l_data, l_ref(qe[c-7], qe[c-7])); end
        end
        checks++; if (bus.o_busy !== exp_busy) begin failures++; $display("FAIL b2b_busy cycle=%0d got=%b exp=%b", c, bus.o_busy, exp_busy); end
      end
      bus.i_valid = (c < 8);
      bus.i_l_data = (c < 8) ? lr[c] : '0;
      bus.i_r_old = (c < 8) ? ro[c] : '0;
      bus.i_r_valid = (c >= 6 && c < 14);
      bus.i_r_new = (c >= 6 && c < 14) ? qe[c-6] : '0;
    end
    idle_inputs();
    checks++; if (bus.o_align_error !== 1'b0) begin failures++; $display("FAIL b2b_align got=%b exp=0", bus.o_align_error); end
  endtask

  task automatic test_random_rows();
    localparam int NC = 32;
    logic iv[NC];
    logic [DW-1:0] lr[NC], ro[NC], rn[NC], qe[NC];
    logic exp_lv;
    for (int j = 0; j < NC; j++) begin
      iv[j] = 1'($urandom_range(0, 1));
      lr[j] = rand_row(); ro[j] = rand_row(); rn[j] = rand_row();
      qe[j] = q_ref(lr[j], ro[j]);
    end
    for (int c = 0; c <= NC + 8; c++) begin
      if (c > 0) begin
        step();
        if (c <= NC) begin
          checks++; if (bus.o_q_valid !== iv[c-1]) begin failures++; $display("FAIL rnd_q_valid cycle=%0d got=%b exp=%b", c, bus.o_q_valid, iv[c-1]); end
          if (iv[c-1]) begin
            checks++; if (bus.o_q_data !== qe[c-1]) begin failures++; $display("FAIL rnd_q_data cycle=%0d got=%h exp=%h", c, bus.o_q_data, qe[c-1]); end
          end
        end
        exp_lv = (c >= 7 && c - 7 < NC) ? iv[c-7] : 1'b0;
        checks++; if (bus.o_l_valid !== exp_lv) begin failures++; $display("FAIL rnd_l_valid cycle=%0d got=%b exp=%b", c, bus.o_l_valid, exp_lv); end
        if (exp_lv) begin
          checks++; if (bus.o_l_data !== l_ref(qe[c-7], rn[c-7])) begin failures++; $display("FAIL rnd_l_data cycle=%0d got=%h exp=%h", c, bus.o_l_data, l_ref(qe[c-7], rn[c-7])); end
        end
      end
      bus.i_valid = (c < NC) ? iv[c] : 1'b0;
      bus.i_l_data = (c < NC) ? lr[c] : '0;
      bus.i_r_old = (c < NC) ? ro[c] : '0;
      bus.i_r_valid = (c >= 6 && c - 6 < NC) ? iv[c-6] : 1'b0;
      bus.i_r_new = (c >= 6 && c - 6 < NC) ? rn[c-6] : '0;
    end
    idle_inputs();
    checks++; if (bus.o_align_error !== 1'b0) begin failures++; $display("FAIL rnd_align got=%b exp=0", bus.o_align_error); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL rnd_busy_end got=%b exp=0", bus.o_busy); end
  endtask

  task automatic test_misalign();
    logic exp_err;
    bus.i_valid = 1'b1; bus.i_l_data = rand_row(); bus.i_r_old = rand_row();
    for (int c = 1; c <= 10; c++) begin
      step();
      idle_inputs();
      exp_err = (c >= 6);
      checks++; if (bus.o_l_valid !== 1'b0) begin failures++; $display("FAIL mis_l_valid cycle=%0d got=%b exp=0", c, bus.o_l_valid); end
      checks++; if (bus.o_align_error !== exp_err) begin failures++; $display("FAIL mis_align cycle=%0d got=%b exp=%b", c, bus.o_align_error, exp_err); end
      if (c == 5) begin
        bus.i_r_valid = 1'b1; bus.i_r_new = rand_row();
      end
    end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL mis_busy_end got=%b exp=0", bus.o_busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.o_align_error !== 1'b0) begin failures++; $display("FAIL mis_align_cleared got=%b exp=0", bus.o_align_error); end
    step();
  endtask

  task automatic test_reset_midflight();
    logic [DW-1:0] l, ro, rn, qe;
    l = rand_row(); ro = rand_row();
    l[7:0] = 8'd50; ro[7:0] = 8'd0;
    bus.i_valid = 1'b1; bus.i_l_data = l; bus.i_r_old = ro;
    step();
    idle_inputs();
    step(); step();
    rst = 1'b1;
    #1;
    checks++; if (bus.o_q_data !== '0) begin failures++; $display("FAIL mid_q_data got=%h exp=0", bus.o_q_data); end
    checks++; if (bus.o_q_valid !== 1'b0) begin failures++; $display("FAIL mid_q_valid got=%b exp=0", bus.o_q_valid); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", bus.o_busy); end
    checks++; if (bus.o_l_valid !== 1'b0 || bus.o_l_data !== '0 || bus.o_align_error !== 1'b0) begin
      failures++; $display("FAIL mid_l_outputs got=%b/%h/%b exp=0/0/0", bus.o_l_valid, bus.o_l_data, bus.o_align_error);
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++; if (bus.o_l_valid !== 1'b0 || bus.o_busy !== 1'b0) begin failures++; $display("FAIL mid_after_reset cycle=%0d l_valid=%b busy=%b exp=0/0", c, bus.o_l_valid, bus.o_busy); end
    end
    l = rand_row(); ro = rand_row(); rn = rand_row();
    qe = q_ref(l, ro);
    bus.i_valid = 1'b1; bus.i_l_data = l; bus.i_r_old = ro;
    step();
    idle_inputs();
    checks++; if (bus.o_q_data !== qe) begin failures++; $display("FAIL mid_next_q got=%h exp=%h", bus.o_q_data, qe); end
    for (int c = 2; c <= 7; c++) begin
      step();
      bus.i_r_valid = (c == 6);
      bus.i_r_new = (c == 6) ? rn : '0;
    end
    checks++; if (bus.o_l_valid !== 1'b1) begin failures++; $display("FAIL mid_next_l_valid got=%b exp=1", bus.o_l_valid); end
    checks++; if (bus.o_l_data !== l_ref(qe, rn)) begin failures++; $display("FAIL mid_next_l_data got=%h exp=%h", bus.o_l_data, l_ref(qe, rn)); end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_row();
    test_saturation();
    test_back_to_back();
    test_random_rows();
    test_misalign();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
